vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port video RAM between the XERA4 CPU video port and the display fetch engine. Display reads have absolute priority and a fixed 2-cycle latency. CPU writes are posted into a small write buffer. CPU reads are ordered behind all buffered writes. The block sits between the CPU's video bus and the VRAM, and every VRAM access passes through it.

## Interface
Parameters:
- AW, 15, VRAM address width (matches CPU video address)
- DW, 8, VRAM data width
- WDEPTH, 4, write-buffer entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, valid while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- disp_req  in  1  display read request, may be asserted every cycle
- disp_addr  in  AW  display read address
- disp_rdata  out  DW  display read data
- disp_valid  out  1  disp_rdata valid, one cycle per request
- vram_addr  out  AW  RAM address, registered
- vram_wdata  out  DW  RAM write data, registered
- vram_we  out  1  RAM write enable, registered
- vram_rdata  in  DW  RAM read data, 1-cycle synchronous read
- wbuf_level  out  $clog2(WDEPTH)+1  buffered write count

## Operation
- Reset values: every output is 0. The write buffer is emptied, any read in flight is dropped, and the FSM goes to IDLE.
- Each edge grants at most one VRAM slot. Priority: display read, then CPU read, then write-buffer drain.
- A CPU read is granted only when the write buffer is empty. This keeps read-after-write ordering without forwarding.
- CPU write accept: the write is accepted when cpu_req=1, cpu_we=1, the buffer is not full, cpu_ready=0, and no read is outstanding. The entry {addr, data} is pushed and cpu_ready pulses on the next cycle.
- Full is evaluated before the same-edge pop, so a push into a full buffer stalls even if a drain happens on that edge.
- cpu_req is ignored on any edge where cpu_ready=1. The requester changes or drops its request in that cycle.
- Read FSM states:
  - IDLE → RD_PEND when a read is accepted (cpu_req=1, cpu_we=0, cpu_ready=0). The address is latched.
  - RD_PEND → RD_ISSUE when the read wins a slot (no disp_req, buffer empty).
  - RD_ISSUE → RD_DATA unconditionally.
  - RD_DATA → IDLE. vram_rdata is captured into cpu_rdata and cpu_ready=1 for exactly that cycle.
- While the read FSM is not IDLE, new CPU requests are not accepted.
- Drain: pop the oldest entry and drive vram_addr, vram_wdata and vram_we=1 for one cycle.
- On slots that are not write slots, vram_we=0. vram_wdata holds its last value.
- No starvation guard. The display engine must leave idle cycles, and the CPU may stall indefinitely while disp_req is held.

## Timing
- Display: disp_req sampled at edge N → vram_addr=disp_addr after N → RAM read at N+1 → disp_rdata latched at N+2 with disp_valid=1 for one cycle. Fixed latency 2. A request every cycle gives a result every cycle.
- CPU write: accepted at edge N → cpu_ready=1 during N..N+1 → earliest RAM write at N+1. The write may be delayed indefinitely by display traffic.
- CPU read, uncontended with an empty buffer: accepted at N, issued at N+1, RAM read at N+2, cpu_ready/cpu_rdata valid after N+3. Minimum latency 3.
- wbuf_level updates the cycle after each push or pop. A simultaneous push and pop leaves it unchanged.
- Buffer pointers wrap modulo WDEPTH. Full is level==WDEPTH; empty is level==0.
- rst_n=0 mid-read or mid-drain: takes effect at that edge. All outputs are 0 after it and no cpu_ready or disp_valid is emitted for the aborted access.

## Structure
- Shared package xera4_pkg holds:
  - XERA4_AW=15 and XERA4_DW=8.
  - Grant enum: GNT_NONE, GNT_DISP, GNT_CPURD, GNT_CPUWR.
  - Read-FSM enum: RD_IDLE, RD_PEND, RD_ISSUE, RD_DATA.
- One sub-module, vram_wbuf: synchronous FIFO (push, pop, full, empty, level, head entry). Same clk and rst_n.
- Grant logic, read FSM and output registers live in vram_arbiter.

## Test plan
- Reset hold: all outputs 0. Write 0x12 to 0x0100, then assert rst_n=0 before the drain → no vram_we is seen and wbuf_level=0.
- Display stream: disp_req on 8 consecutive cycles, addresses 0x4000–0x4007, RAM model returns addr[7:0] → disp_valid on 8 consecutive cycles, each 2 cycles after its request, data 0x00–0x07.
- Write buffer full: 5 back-to-back CPU writes with disp_req held high → 4 cpu_ready pulses, the 5th stalls. Drop disp_req → writes 0xA0–0xA4 reach the RAM in order and wbuf_level returns to 0.
- Read-after-write: write 0x55 to 0x0200, immediately read 0x0200 → the read issues only after the write drains, and cpu_rdata=0x55.
- Contention: CPU read pending while disp_req alternates 1/0 → the CPU read is issued on the first cycle with disp_req=0, and every display latency remains exactly 2.
- Back-to-back protocol: cpu_req held high through cpu_ready → exactly one access per request and no duplicate RAM write.

Source files
------------

// File: rtl/xera4_pkg.sv
// Shared XERA4 video-subsystem definitions: bus widths, the slot-grant
// encoding and the CPU read-sequencer states.
package xera4_pkg;

  localparam int XERA4_AW = 15;
  localparam int XERA4_DW = 8;

  // Owner of the VRAM slot on a given edge
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_CPURD,
    GNT_CPUWR
  } grant_e;

  // CPU read sequencer
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PEND,
    RD_ISSUE,
    RD_DATA
  } rd_state_e;

endpackage

// File: rtl/vram_wbuf.sv
// Posted-write buffer: a small synchronous FIFO of {addr, data} entries.
// The head entry is visible combinationally so the arbiter can drain it in
// the same cycle it wins a slot.
module vram_wbuf #(
  parameter int EW    = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [EW-1:0]            i_push_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [EW-1:0]            o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Entry storage, written on accepted pushes
  // NOTE: storage has no reset; an entry is only ever read after it is
  // written, and leaving it out keeps the array as plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
  // NOTE: all state is updated with <= so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the display fetch engine and the XERA4
// CPU video port. Display reads always win the slot; CPU reads wait for the
// write buffer to drain so no forwarding path is needed.
module vram_arbiter
  import xera4_pkg::*;
#(
  parameter int AW     = XERA4_AW,
  parameter int DW     = XERA4_DW,
  parameter int WDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [AW-1:0]           cpu_addr,
  input  logic [DW-1:0]           cpu_wdata,
  output logic [DW-1:0]           cpu_rdata,
  output logic                    cpu_ready,
  input  logic                    disp_req,
  input  logic [AW-1:0]           disp_addr,
  output logic [DW-1:0]           disp_rdata,
  output logic                    disp_valid,
  output logic [AW-1:0]           vram_addr,
  output logic [DW-1:0]           vram_wdata,
  output logic                    vram_we,
  input  logic [DW-1:0]           vram_rdata,
  output logic [$clog2(WDEPTH):0] wbuf_level
);

  rd_state_e     r_rd_state;
  logic [AW-1:0] r_rd_addr;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_cpu_ready;
  logic [DW-1:0] r_disp_rdata;
  logic          r_disp_valid;
  logic          r_disp_p1;
  logic          r_disp_p2;
  logic [AW-1:0] r_vram_addr;
  logic [DW-1:0] r_vram_wdata;
  logic          r_vram_we;

  grant_e           w_gnt;
  logic             w_cpu_take;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_full;
  logic             w_empty;
  logic [AW+DW-1:0] w_head;

  // A request is considered only outside the ready pulse and with no read in flight
  assign w_cpu_take = cpu_req && !r_cpu_ready && (r_rd_state == RD_IDLE);
  assign w_wr_acc   = w_cpu_take && cpu_we && !w_full;
  assign w_rd_acc   = w_cpu_take && !cpu_we;

  vram_wbuf #(
    .EW    (AW + DW),
    .DEPTH (WDEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_wr_acc),
    .i_push_data ({cpu_addr, cpu_wdata}),
    .i_pop       (w_gnt == GNT_CPUWR),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (wbuf_level),
    .o_head      (w_head)
  );

  // Slot priority: display, then CPU read (buffer empty only), then drain
  // NOTE: w_gnt gets a default before the if-chain so no latch is inferred.
  always_comb begin
    w_gnt = GNT_NONE;
    if (disp_req)                                 w_gnt = GNT_DISP;
    else if ((r_rd_state == RD_PEND) && w_empty)  w_gnt = GNT_CPURD;
    else if (!w_empty)                            w_gnt = GNT_CPUWR;
  end

  // RAM port registers; write data holds between write slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
      r_vram_we    <= 1'b0;
    end else begin
      r_vram_we <= 1'b0;
      case (w_gnt)
        GNT_DISP:  r_vram_addr <= disp_addr;
        GNT_CPURD: r_vram_addr <= r_rd_addr;
        GNT_CPUWR: begin
          r_vram_addr  <= w_head[AW+DW-1:DW];
          r_vram_wdata <= w_head[DW-1:0];
          r_vram_we    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Display return pipeline: issue edge, RAM read edge, capture edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp_p1    <= 1'b0;
      r_disp_p2    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_rdata <= '0;
    end else begin
      r_disp_p1    <= (w_gnt == GNT_DISP);
      r_disp_p2    <= r_disp_p1;
      r_disp_valid <= r_disp_p2;
      if (r_disp_p2) r_disp_rdata <= vram_rdata;
    end
  end

  // CPU read sequencer with registered cpu_ready / cpu_rdata
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_state  <= RD_IDLE;
      r_rd_addr   <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ready <= 1'b0;
    end else begin
      r_cpu_ready <= w_wr_acc;
      case (r_rd_state)
        RD_IDLE: begin
          if (w_rd_acc) begin
            r_rd_addr  <= cpu_addr;
            r_rd_state <= RD_PEND;
          end
        end
        RD_PEND:  if (w_gnt == GNT_CPURD) r_rd_state <= RD_ISSUE;
        RD_ISSUE: r_rd_state <= RD_DATA;
        RD_DATA: begin
          r_cpu_rdata <= vram_rdata;
          r_cpu_ready <= 1'b1;
          r_rd_state  <= RD_IDLE;
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_ready  = r_cpu_ready;
  assign disp_rdata = r_disp_rdata;
  assign disp_valid = r_disp_valid;
  assign vram_addr  = r_vram_addr;
  assign vram_wdata = r_vram_wdata;
  assign vram_we    = r_vram_we;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural 1-cycle VRAM, scoreboard
// queues for display returns and RAM writes, directed CPU transactions.
module tb_vram_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  typedef struct {
    logic [7:0] data;
    int         due;
  } disp_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_valid;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata, vram_rdata;
  logic          vram_we;
  logic [2:0]    wbuf_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_disp = 0;
  int n_we = 0;

  disp_exp_t        disp_q[$];
  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    rd_q[$];
  disp_exp_t        mon_de;
  logic [AW+DW-1:0] mon_we;
  logic [DW-1:0]    ram [1<<AW];

  vram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_rdata (disp_rdata),
    .disp_valid (disp_valid),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_rdata (vram_rdata),
    .wbuf_level (wbuf_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // VRAM model: unwritten locations read back addr[7:0]
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      ram[i] = a[7:0];
    end
  end

  always @(posedge clk) begin
    if (vram_we) ram[vram_addr] <= vram_wdata;
    vram_rdata <= ram[vram_addr];
    cyc <= cyc + 1;
  end

  // Display expectations are derived from the stimulus as the DUT samples it
  always @(posedge clk) begin
    if (!rst_n) disp_q.delete();
    else if (disp_req) disp_q.push_back('{disp_addr[7:0], cyc + 3});
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (disp_valid) begin
      n_disp++;
      if (disp_q.size() == 0) check("disp_unexp", disp_valid, 1'b0);
      else begin
        mon_de = disp_q.pop_front();
        check("disp_data", disp_rdata, mon_de.data);
        check("disp_lat", cyc, mon_de.due);
      end
    end
    if (vram_we) begin
      n_we++;
      if (wr_q.size() == 0) check("wr_unexp", vram_we, 1'b0);
      else begin
        mon_we = wr_q.pop_front();
        check("wr_addr", vram_addr, mon_we[AW+DW-1:DW]);
        check("wr_data", vram_wdata, mon_we[DW-1:0]);
      end
    end
  end

  task automatic disp_burst(input int n, input logic [AW-1:0] base, input bit alt);
    for (int i = 0; i < n; i++) begin
      disp_req  = alt ? i[0] : 1'b1;
      disp_addr = base + AW'(i);
      @(negedge clk);
    end
    disp_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit expect_drain, input int budget, output bit ok);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    if (expect_drain) wr_q.push_back({a, d});
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        ok = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input int exp_lat, input int budget);
    int  t0;
    bit  got;
    logic [DW-1:0] e;
    t0       = cyc;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = a;
    rd_q.push_back(exp);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        got = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
    check("rd_done", got, 1'b1);
    if (got) begin
      e = rd_q.pop_front();
      check("rd_data", cpu_rdata, e);
      if (exp_lat != 0) check("rd_lat", cyc - t0, exp_lat);
    end else rd_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vram_we"}, vram_we, 0);
    check({tag, "_vram_addr"}, vram_addr, 0);
    check({tag, "_vram_wdata"}, vram_wdata, 0);
    check({tag, "_cpu_ready"}, cpu_ready, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_disp_valid"}, disp_valid, 0);
    check({tag, "_disp_rdata"}, disp_rdata, 0);
    check({tag, "_level"}, wbuf_level, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t0, we0, d0;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_req = 1'b0; disp_addr = '0;
    idle(3);
    check_all_zero("rst");
    rst_n = 1'b1;
    idle(2);

    // Reset before the buffered write can drain: write must vanish
    we0 = n_we;
    fork
      disp_burst(6, 15'h4100, 1'b0);
      begin
        cpu_write(15'h0100, 8'h12, 1'b0, 10, ok);
        check("rstw_ready", ok, 1'b1);
        check("rstw_level", wbuf_level, 1);
        rst_n = 1'b0;
        idle(1);
        check_all_zero("midrst");
        rst_n = 1'b1;
      end
    join
    idle(8);
    check("rstw_no_we", n_we - we0, 0);
    check("rstw_level0", wbuf_level, 0);

    // Display stream: 8 back-to-back reads, latency checked by the monitor
    d0 = n_disp;
    disp_burst(8, 15'h4000, 1'b0);
    idle(4);
    check("disp_count", n_disp - d0, 8);
    check("disp_q_empty", disp_q.size(), 0);

    // Buffer full under display pressure; 5th write waits for a real pop
    fork
      disp_burst(14, 15'h4080, 1'b0);
      begin
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
          cpu_write(15'h0010 + AW'(i), 8'hA0 + DW'(i), 1'b1, 10, ok);
          check("full_wr_ready", ok, 1'b1);
        end
        check("full_level4", wbuf_level, 4);
        cpu_write(15'h0014, 8'hA4, 1'b1, 40, ok);
        check("full_wr5_ready", ok, 1'b1);
        check("full_wr5_cycle", cyc - t0, 16);
      end
    join
    for (int i = 0; i < 20 && wbuf_level != 0; i++) idle(1);
    check("full_level0", wbuf_level, 0);
    idle(2);
    check("full_drained", wr_q.size(), 0);

    // Read-after-write while the drain is held off by display traffic
    fork
      disp_burst(6, 15'h4040, 1'b0);
      begin
        cpu_write(15'h0200, 8'h55, 1'b1, 10, ok);
        check("raw_wr_ready", ok, 1'b1);
        cpu_read(15'h0200, 8'h55, 0, 40);
      end
    join
    idle(4);

    // Uncontended read: minimum latency
    cpu_read(15'h0321, 8'h21, 4, 20);
    idle(2);

    // Contention: read waits for the first display-free slot
    fork
      disp_burst(8, 15'h4060, 1'b1);
      cpu_read(15'h0377, 8'h77, 5, 20);
    join
    idle(4);

    // Back-to-back writes with cpu_req held through cpu_ready
    we0 = n_we;
    cpu_write(15'h0123, 8'h3C, 1'b1, 10, ok);
    check("b2b_ready1", ok, 1'b1);
    cpu_write(15'h0123, 8'h3C, 1'b1, 10, ok);
    check("b2b_ready2", ok, 1'b1);
    idle(6);
    check("b2b_we_count", n_we - we0, 2);
    check("b2b_level0", wbuf_level, 0);

    check("end_disp_q", disp_q.size(), 0);
    check("end_wr_q", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
